// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples multiplexed 7-segment scan lines, decodes each digit back to BCD and
// publishes coherent MM:SS frames. Define SEG_SCAN_TIMEOUT_EN to add the frame watchdog (stale).
module seg_scan_decoder #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [3:0] dig,
  output logic [2:0] min1,
  output logic [3:0] min2,
  output logic [2:0] sec1,
  output logic [3:0] sec2,
  output logic [3:0] blank_mask,
  output logic       frame_valid,
  output logic       pattern_err,
  output logic       stale
);

  localparam int               CNT_W      = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
  // Digit positions (dig bit index) that carry tens values limited to 0-5.
  localparam logic [3:0]       TENS_MASK  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } state_e;

  typedef struct packed {
    logic       illegal;
    logic       blank;
    logic [3:0] value;
  } glyph_t;

  function automatic glyph_t decode(input logic [6:0] p);
    glyph_t g;
    g = '0;
    case (p)
      7'b1111110: g.value = 4'd0;
      7'b0110000: g.value = 4'd1;
      7'b1101101: g.value = 4'd2;
      7'b1111001: g.value = 4'd3;
      7'b0110011: g.value = 4'd4;
      7'b1011011: g.value = 4'd5;
      7'b1011111: g.value = 4'd6;
      7'b1110000: g.value = 4'd7;
      7'b1111111: g.value = 4'd8;
      7'b1111011: g.value = 4'd9;
      7'b0000000: g.blank = 1'b1;
      default:    g.illegal = 1'b1;
    endcase
    return g;
  endfunction

  logic [6:0]       seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_prev_q, seg_prev_d;
  logic [3:0]       dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d, dig_prev_q, dig_prev_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0][3:0]  shadow_q, shadow_d;
  logic [3:0]       shadow_blank_q, shadow_blank_d;
  logic [3:0]       captured_q, captured_d;
  logic [2:0]       min1_q, min1_d, sec1_q, sec1_d;
  logic [3:0]       min2_q, min2_d, sec2_q, sec2_d;
  logic [3:0]       blank_mask_q, blank_mask_d;
  logic             frame_valid_q, frame_valid_d;
  logic             pattern_err_q, pattern_err_d;

  logic [6:0]       seg_n;
  logic [3:0]       dig_n;
  logic             one_hot, seg_changed, dig_changed, capture;
  glyph_t           glyph;

`ifdef SEG_SCAN_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            stale_q, stale_d;
  assign stale = stale_q;
`else
  assign stale = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    seg_s1_d       = seg;
    seg_s2_d       = seg_s1_q;
    dig_s1_d       = dig;
    dig_s2_d       = dig_s1_q;
    seg_n          = SEG_ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;
    dig_n          = DIG_ACTIVE_LOW ? ~dig_s2_q : dig_s2_q;
    seg_prev_d     = seg_n;
    dig_prev_d     = dig_n;
    one_hot        = $onehot(dig_n);
    seg_changed    = (seg_n != seg_prev_q);
    dig_changed    = (dig_n != dig_prev_q);
    glyph          = decode(seg_n);
    capture        = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;
    shadow_d       = shadow_q;
    shadow_blank_d = shadow_blank_q;
    captured_d     = captured_q;
    min1_d         = min1_q;
    min2_d         = min2_q;
    sec1_d         = sec1_q;
    sec2_d         = sec2_q;
    blank_mask_d   = blank_mask_q;
    frame_valid_d  = 1'b0;
    pattern_err_d  = pattern_err_q;

    case (state_q)
      IDLE: begin
        if (one_hot) begin
          state_d = SETTLE;
          cnt_d   = CNT_ONE;
        end
      end
      SETTLE: begin
        if (seg_changed || dig_changed) begin
          state_d = one_hot ? SETTLE : IDLE;
          cnt_d   = CNT_ONE;
        end else if (cnt_q >= SETTLE_MAX) begin
          state_d = CAPTURED;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CAPTURED: begin
        // Segment changes during a captured dwell are ignored; only a new digit select restarts.
        if (dig_changed) begin
          state_d = one_hot ? SETTLE : IDLE;
          cnt_d   = CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SEG_SCAN_TIMEOUT_EN
    wd_d    = wd_q;
    stale_d = stale_q;
    if (wd_q != WD_MAX) wd_d = wd_q + WD_W'(1);
    if (wd_q == WD_LAST) begin
      stale_d    = 1'b1;
      captured_d = '0;
    end
`endif

    if (capture) begin
      if (glyph.illegal) begin
        pattern_err_d = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (dig_n[i]) begin
            shadow_d[i]       = TENS_MASK[i] ? {1'b0, glyph.value[2:0]} : glyph.value;
            shadow_blank_d[i] = glyph.blank;
            captured_d[i]     = 1'b1;
            if (TENS_MASK[i] && (glyph.value > 4'd5)) pattern_err_d = 1'b1;
          end
        end
      end
    end

    if (captured_d == 4'hF) begin
      min1_d        = shadow_d[3][2:0];
      min2_d        = shadow_d[2];
      sec1_d        = shadow_d[1][2:0];
      sec2_d        = shadow_d[0];
      blank_mask_d  = shadow_blank_d;
      frame_valid_d = 1'b1;
      captured_d    = '0;
    end

`ifdef SEG_SCAN_TIMEOUT_EN
    if (frame_valid_d) begin
      wd_d    = '0;
      stale_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_s1_q       <= '0;
      seg_s2_q       <= '0;
      seg_prev_q     <= '0;
      dig_s1_q       <= '0;
      dig_s2_q       <= '0;
      dig_prev_q     <= '0;
      state_q        <= IDLE;
      cnt_q          <= '0;
      // NOTE: the digit shadow store is reset too, so no old digit can leak into a later frame.
      shadow_q       <= '0;
      shadow_blank_q <= '0;
      captured_q     <= '0;
      min1_q         <= '0;
      min2_q         <= '0;
      sec1_q         <= '0;
      sec2_q         <= '0;
      blank_mask_q   <= '0;
      frame_valid_q  <= 1'b0;
      pattern_err_q  <= 1'b0;
    end else begin
      // NOTE: flops take non-blocking assignments only; all next-state math is blocking, above.
      seg_s1_q       <= seg_s1_d;
      seg_s2_q       <= seg_s2_d;
      seg_prev_q     <= seg_prev_d;
      dig_s1_q       <= dig_s1_d;
      dig_s2_q       <= dig_s2_d;
      dig_prev_q     <= dig_prev_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      shadow_blank_q <= shadow_blank_d;
      captured_q     <= captured_d;
      min1_q         <= min1_d;
      min2_q         <= min2_d;
      sec1_q         <= sec1_d;
      sec2_q         <= sec2_d;
      blank_mask_q   <= blank_mask_d;
      frame_valid_q  <= frame_valid_d;
      pattern_err_q  <= pattern_err_d;
    end
  end

`ifdef SEG_SCAN_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q    <= '0;
      stale_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      stale_q <= stale_d;
    end
  end
`endif

  assign min1        = min1_q;
  assign min2        = min2_q;
  assign sec1        = sec1_q;
  assign sec2        = sec2_q;
  assign blank_mask  = blank_mask_q;
  assign frame_valid = frame_valid_q;
  assign pattern_err = pattern_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a dwell-level display model predicts each published frame.
// With SEG_SCAN_TIMEOUT_EN defined the bench runs the watchdog scenario instead of the main suite.
module tb_seg_scan_decoder;

  localparam int SETTLE = 4;
`ifdef SEG_SCAN_TIMEOUT_EN
  localparam int TIMEOUT = 64;
`else
  localparam int TIMEOUT = 1 << 20;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg;
  logic [3:0] dig;
  logic [2:0] min1, sec1;
  logic [3:0] min2, sec2, blank_mask;
  logic       frame_valid, pattern_err, stale;

  seg_scan_decoder #(
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg         (seg),
    .dig         (dig),
    .min1        (min1),
    .min2        (min2),
    .sec1        (sec1),
    .sec2        (sec2),
    .blank_mask  (blank_mask),
    .frame_valid (frame_valid),
    .pattern_err (pattern_err),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] min1;
    logic [3:0] min2;
    logic [2:0] sec1;
    logic [3:0] sec2;
    logic [3:0] blank;
    logic       err;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     frames_seen = 0;

  // Display model: what the display shows per digit position (index = dig bit).
  int m_val[4];
  bit m_blank[4];
  bit m_cap[4];
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      default: return 7'b1111011;
    endcase
  endfunction

  function automatic int glyph_value(input logic [6:0] p);
    for (int d = 0; d < 10; d++) if (glyph(d) == p) return d;
    return -1;
  endfunction

  function automatic logic [6:0] rand_illegal();
    logic [6:0] p;
    do p = 7'($urandom); while (p == 7'b0 || glyph_value(p) >= 0);
    return p;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 0; m_blank[i] = 0; m_cap[i] = 0;
    end
    m_err = 0;
    exp_q.delete();
  endfunction

  // A dwell that stayed stable long enough delivers one digit to the model.
  function automatic void model_capture(input int k, input logic [6:0] p);
    int     v;
    bit     tens;
    frame_t f;
    v    = glyph_value(p);
    tens = (k == 3) || (k == 1);
    if (p == 7'b0) begin
      m_val[k] = 0; m_blank[k] = 1; m_cap[k] = 1;
    end else if (v < 0) begin
      m_err = 1;
    end else begin
      if (tens && v > 5) m_err = 1;
      m_val[k]   = tens ? v % 8 : v;
      m_blank[k] = 0;
      m_cap[k]   = 1;
    end
    if (m_cap[0] && m_cap[1] && m_cap[2] && m_cap[3]) begin
      f.min1  = 3'(m_val[3]);
      f.min2  = 4'(m_val[2]);
      f.sec1  = 3'(m_val[1]);
      f.sec2  = 4'(m_val[0]);
      f.blank = {m_blank[3], m_blank[2], m_blank[1], m_blank[0]};
      f.err   = m_err;
      exp_q.push_back(f);
      for (int i = 0; i < 4; i++) m_cap[i] = 0;
    end
  endfunction

  // Drive one cycle: k = digit bit index, or -1 for no digit selected. Lines are active-low.
  task automatic drive(input int k, input logic [6:0] p);
    @(posedge clk); #1;
    seg = ~p;
    dig = (k < 0) ? 4'hF : ~(4'b0001 << k);
  endtask

  task automatic dwell(input int k, input logic [6:0] p, input int hold, input int glitches);
    logic [6:0] m1, m2;
    int         gap;
    m1 = 7'($urandom_range(1, 126));
    m2 = ~m1;
    for (int i = 0; i < glitches; i++) drive(k, p ^ (((i % 2) == 0) ? m1 : m2));
    for (int i = 0; i < hold; i++) drive(k, p);
    if (hold >= SETTLE + 1) model_capture(k, p);
    gap = $urandom_range(1, 2);
    for (int i = 0; i < gap; i++) drive(-1, 7'($urandom));
  endtask

  task automatic scan4(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1,
                       input logic [6:0] p0);
    dwell(3, p3, 8, 0);
    dwell(2, p2, 8, 0);
    dwell(1, p1, 8, 0);
    dwell(0, p0, 8, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(-1, 7'h00);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_min1"}, 32'(min1), 0);
    check({tag, "_min2"}, 32'(min2), 0);
    check({tag, "_sec1"}, 32'(sec1), 0);
    check({tag, "_sec2"}, 32'(sec2), 0);
    check({tag, "_blank"}, 32'(blank_mask), 0);
    check({tag, "_fv"}, 32'(frame_valid), 0);
    check({tag, "_err"}, 32'(pattern_err), 0);
    check({tag, "_stale"}, 32'(stale), 0);
    seg = 7'h7F;
    dig = 4'hF;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: compares every published frame against the head of the expected queue.
  logic fv_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset && frame_valid) begin
      frame_t f;
      frames_seen++;
      check("fv_single_pulse", 32'(fv_prev), 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: got min1=%0d min2=%0d sec1=%0d sec2=%0d, expected no frame",
                 min1, min2, sec1, sec2);
      end else begin
        f = exp_q.pop_front();
        check("frame_min1", 32'(min1), 32'(f.min1));
        check("frame_min2", 32'(min2), 32'(f.min2));
        check("frame_sec1", 32'(sec1), 32'(f.sec1));
        check("frame_sec2", 32'(sec2), 32'(f.sec2));
        check("frame_blank", 32'(blank_mask), 32'(f.blank));
        check("frame_err", 32'(pattern_err), 32'(f.err));
`ifndef SEG_SCAN_TIMEOUT_EN
        check("frame_stale", 32'(stale), 0);
`endif
      end
    end
    fv_prev <= reset ? 1'b0 : frame_valid;
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: got no end of run, expected finish");
    $fatal(1);
  end

  initial begin
    int seen;
    logic [6:0] p;
    reset = 1'b1;
    seg   = 7'h7F;
    dig   = 4'hF;
    apply_reset("rst_init");

`ifdef SEG_SCAN_TIMEOUT_EN
    idle(50);
    check("wd_not_yet_stale", 32'(stale), 0);
    idle(20);
    check("wd_stale_set", 32'(stale), 1);
    scan4(glyph(1), glyph(2), glyph(3), glyph(4));
    idle(10);
    check("wd_stale_cleared", 32'(stale), 0);
    check("wd_frames_drained", 32'(exp_q.size()), 0);
`else
    // Plain scan of 12:34.
    scan4(glyph(1), glyph(2), glyph(3), glyph(4));
    idle(10);
    check("t2_drained", 32'(exp_q.size()), 0);

    // Glitching segments settle on 7 in the seconds-ones position.
    dwell(3, glyph(0), 8, 0);
    dwell(2, glyph(5), 8, 0);
    dwell(1, glyph(4), 8, 0);
    dwell(0, glyph(7), 8, 3);
    idle(10);
    check("t3_drained", 32'(exp_q.size()), 0);

    // Illegal pattern: flags the error but captures nothing.
    check("t4_err_clear", 32'(pattern_err), 0);
    dwell(2, 7'b1000001, 8, 0);
    idle(10);
    check("t4_err_illegal", 32'(pattern_err), 1);
    // Tens digit showing 8 is flagged and stored truncated.
    scan4(glyph(8), glyph(2), glyph(0), glyph(1));
    idle(10);
    check("t4_drained", 32'(exp_q.size()), 0);

    // Blank seconds-tens digit.
    scan4(glyph(5), glyph(9), 7'b0000000, glyph(9));
    idle(10);
    check("t5_drained", 32'(exp_q.size()), 0);

    // Reset mid-dwell with a partial frame already captured.
    dwell(3, glyph(3), 8, 0);
    dwell(2, glyph(1), 8, 0);
    for (int i = 0; i < 3; i++) drive(1, glyph(5));
    apply_reset("rst_mid");
    seen = frames_seen;
    dwell(1, glyph(2), 8, 0);
    dwell(0, glyph(6), 8, 0);
    dwell(2, glyph(4), 8, 0);
    idle(12);
    check("t1_no_partial_frame", 32'(frames_seen - seen), 0);
    dwell(3, glyph(4), 8, 0);
    idle(10);
    check("t1_fresh_frame", 32'(frames_seen - seen), 1);

    // Short dwells must never capture; the minimum settled dwell must.
    dwell(3, glyph(2), SETTLE - 1, 0);
    dwell(2, glyph(3), SETTLE + 1, 2);
    dwell(1, glyph(4), SETTLE + 1, 0);
    dwell(0, glyph(5), SETTLE + 1, 1);
    dwell(3, glyph(1), SETTLE + 1, 0);
    idle(10);
    check("short_drained", 32'(exp_q.size()), 0);

    // Randomised scan traffic.
    for (int n = 0; n < 80; n++) begin
      int k, sel, hold;
      k   = $urandom_range(0, 3);
      sel = $urandom_range(0, 99);
      if (sel < 80)      p = glyph($urandom_range(0, 9));
      else if (sel < 90) p = 7'b0000000;
      else               p = rand_illegal();
      hold = ($urandom_range(0, 99) < 85) ? $urandom_range(SETTLE + 1, SETTLE + 5)
                                          : $urandom_range(1, SETTLE - 1);
      dwell(k, p, hold, $urandom_range(0, 3));
    end
    idle(12);
    check("rand_drained", 32'(exp_q.size()), 0);
    check("rand_err_final", 32'(pattern_err), 32'(m_err));
    check("stale_tied_low", 32'(stale), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
